// File: rtl/div_arb_seq.sv
// Shared 16-by-8 restoring divider serving NREQ requesters in round-robin order.
// Handshakes: a transfer occurs in any cycle where valid && ready; valid holds, operands stable, until then.
module div_arb_seq #(
   parameter int NREQ = 4,
   parameter int IDW  = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [16*NREQ-1:0]   req_a,
   input  logic [8*NREQ-1:0]    req_b,
   output logic [NREQ-1:0]      req_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [IDW-1:0]       out_id,
   output logic [15:0]          result,
   output logic [15:0]          odd,
   output logic                 busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [7:0]     rem_q, rem_d;
   logic [15:0]    q_q, q_d;
   logic [15:0]    a_q, a_d;
   logic [7:0]     b_q, b_d;
   logic [IDW-1:0] id_q, id_d;
   logic [15:0]    result_q, result_d;
   logic [15:0]    odd_q, odd_d;
   logic           out_valid_q, out_valid_d;
   logic           busy_q, busy_d;

   logic           found_hi, found_lo, accept;
   logic [IDW-1:0] g_hi, g_lo, grant;
   logic [15:0]    a_sel;
   logic [7:0]     b_sel;
   logic [8:0]     t;

   // Grant the lowest requester at or above ptr; otherwise wrap to the lowest below it.
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      g_hi     = '0;
      g_lo     = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid[i]) begin
            if (IDW'(i) >= ptr_q) begin
               if (!found_hi) begin
                  found_hi = 1'b1;
                  g_hi     = IDW'(i);
               end
            end else if (!found_lo) begin
               found_lo = 1'b1;
               g_lo     = IDW'(i);
            end
         end
      end
      grant = found_hi ? g_hi : g_lo;
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (IDW'(i) == grant) begin
            a_sel = req_a[16*i +: 16];
            b_sel = req_b[8*i +: 8];
         end
      end
      accept    = rst_n && (state_q == ST_IDLE) && (found_hi || found_lo);
      req_ready = accept ? (NREQ'(1) << grant) : '0;
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      q_d         = q_q;
      a_d         = a_q;
      b_d         = b_q;
      id_d        = id_q;
      result_d    = result_q;
      odd_d       = odd_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      t           = {rem_q, a_q[cnt_q]};
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               ptr_d  = (grant == IDW'(NREQ-1)) ? '0 : grant + IDW'(1);
               a_d    = a_sel;
               b_d    = b_sel;
               id_d   = grant;
               rem_d  = '0;
               q_d    = '0;
               cnt_d  = 4'd15;
               busy_d = 1'b1;
               if (b_sel == 8'd0) begin
                  result_d    = 16'hFFFF;
                  odd_d       = a_sel;
                  out_valid_d = 1'b1;
                  state_d     = ST_DONE;
               end else begin
                  state_d = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            // rem < B always, so the true difference fits in 8 bits.
            if (t >= {1'b0, b_q}) begin
               rem_d       = t[7:0] - b_q;
               q_d[cnt_q]  = 1'b1;
            end else begin
               rem_d = t[7:0];
            end
            if (cnt_q == 4'd0) begin
               result_d    = q_d;
               odd_d       = {8'h00, rem_d};
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               busy_d      = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         cnt_q       <= '0;
         rem_q       <= '0;
         q_q         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= '0;
         result_q    <= '0;
         odd_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         q_q         <= q_d;
         a_q         <= a_d;
         b_q         <= b_d;
         id_q        <= id_d;
         result_q    <= result_d;
         odd_q       <= odd_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_id    = id_q;
   assign result    = result_q;
   assign odd       = odd_q;
   assign busy      = busy_q;

endmodule
